hovalaag_input_fifo: RTL and testbench
======================================

HOVALAAG_INPUT_FIFO -- requirements
Module: hovalaag_input_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set entries per channel; power of two, minimum 2.
REQ-002 Parameter AW, default 4, SHALL equal log2(DEPTH).
REQ-003 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 wr_valid  input  1  SHALL flag a host word offered for push.
REQ-006 wr_sel  input  1  SHALL select the push channel: 0 = channel 1, 1 = channel 2.
REQ-007 wr_data  input  12  SHALL carry the pushed word.
REQ-008 wr_ready  output  1  SHALL be high when the channel selected by wr_sel is not full (combinational).
REQ-009 IN1  output  12  SHALL present the channel-1 head word.
REQ-010 IN1_adv  input  1  SHALL request a channel-1 pop this cycle.
REQ-011 IN2  output  12  SHALL present the channel-2 head word.
REQ-012 IN2_adv  input  1  SHALL request a channel-2 pop this cycle.
REQ-013 count1, count2  output  AW+1  SHALL give current occupancy per channel.
REQ-014 underflow1, underflow2  output  1  SHALL be sticky flags for a pop while empty.

Function
REQ-015 Each channel SHALL be an independent circular FIFO with read pointer, write pointer (AW bits each, wrapping DEPTH-1 -> 0) and occupancy counter (AW+1 bits).
REQ-016 Push SHALL occur on a clock edge where wr_valid and wr_ready are both high; wr_data is written at the selected channel's write pointer, which then increments.
REQ-017 wr_valid with wr_ready low SHALL leave all state unchanged; no word is dropped or overwritten.
REQ-018 INx SHALL combinationally equal the entry at the read pointer when countx > 0, and 12'h000 when countx = 0.
REQ-019 A word pushed at edge N SHALL first be visible on INx in the cycle after edge N (one-cycle latency, empty to head).
REQ-020 Pop SHALL occur on an edge where INx_adv is high and countx > 0: read pointer increments; next word (if any) appears on INx after that edge.
REQ-021 INx_adv high with countx = 0 SHALL leave pointers and count unchanged and set underflowx to 1.
REQ-022 Simultaneous push and pop on one channel with count in 1..DEPTH-1 SHALL leave count unchanged and advance both pointers.
REQ-023 Simultaneous push and pop on an empty channel SHALL perform the push only, set underflow, and yield count 1.
REQ-024 Simultaneous push and pop on a full channel SHALL perform the pop only, since wr_ready is low; count becomes DEPTH-1.
REQ-025 Channel-1 and channel-2 pops in the same cycle SHALL both be honoured; push to one channel SHALL NOT affect the other.
REQ-026 countx SHALL never exceed DEPTH nor go below 0.
REQ-027 underflowx SHALL stay set until rst; no other event clears it.

Reset
REQ-028 On an edge with rst high: pointers, counts, underflow1/2 SHALL become 0; IN1/IN2 SHALL read 12'h000; wr_ready SHALL read 1.
REQ-029 rst SHALL override simultaneous push and pop; stored words are discarded and memory contents need not be cleared.
REQ-030 Reset mid-stream SHALL make the first post-reset push appear as head with count 1.

Verification
REQ-031 Reset, push 12'h123 to ch1 -> next cycle IN1 = 12'h123, count1 = 1, IN2 = 0, count2 = 0.
REQ-032 Push 16 words 1..16 to ch2 (DEPTH=16) -> count2 = 16, wr_ready low with wr_sel = 1 and high with wr_sel = 0; 17th push ignored; pop 16 -> IN2 sequence 1..16, then IN2 = 0.
REQ-033 ch1 holding 3 words, push + IN1_adv same cycle, repeated 20 cycles -> count1 stays 3, output order preserved across pointer wrap.
REQ-034 Empty ch1, IN1_adv high with push of 12'hABC -> underflow1 = 1, count1 = 1, IN1 = 12'hABC next cycle; underflow1 remains 1 until rst.
REQ-035 Full ch2, push + IN2_adv same cycle -> count2 = 15, pushed word not stored.
REQ-036 rst asserted with both channels half full and adv high -> counts 0, IN1 = IN2 = 0, underflow flags 0.

Source files
------------

// File: rtl/hovalaag_input_fifo.sv
// Dual-channel host input FIFO feeding the IN1/IN2 ports of the Hovalaag core.
// One shared push port steered by wr_sel; each channel pops independently.
module hovalaag_input_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic          wr_sel,
    input  logic [11:0]   wr_data,
    output logic          wr_ready,
    output logic [11:0]   IN1,
    input  logic          IN1_adv,
    output logic [11:0]   IN2,
    input  logic          IN2_adv,
    output logic [AW:0]   count1,
    output logic [AW:0]   count2,
    output logic          underflow1,
    output logic          underflow2
);

    localparam int unsigned W = 12;

    logic [1:0]   adv;
    logic [1:0]   full;
    logic [1:0]   push;
    logic [1:0]   underflow;
    logic [W-1:0] head  [2];
    logic [AW:0]  count [2];

    assign adv = {IN2_adv, IN1_adv};

    // Push is only accepted into a channel with room; a full channel ignores the word.
    assign push[0]  = wr_valid & ~wr_sel & ~full[0];
    assign push[1]  = wr_valid &  wr_sel & ~full[1];
    assign wr_ready = wr_sel ? ~full[1] : ~full[0];

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [W-1:0]  mem [DEPTH];
        logic [AW-1:0] rd_ptr;
        logic [AW-1:0] wr_ptr;
        logic [AW:0]   cnt;
        logic          uf;
        logic          empty;
        logic          pop;

        assign empty     = (cnt == '0);
        assign pop       = adv[g] & ~empty;
        assign full[g]   = (cnt == (AW+1)'(DEPTH));
        assign head[g]   = empty ? '0 : mem[rd_ptr];
        assign count[g]  = cnt;
        assign underflow[g] = uf;

        // Storage is not reset; reset only empties the channel via its pointers.
        always_ff @(posedge clk) begin
            if (!rst && push[g]) begin
                mem[wr_ptr] <= wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                uf     <= 1'b0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                // Sticky until reset: any advance request against an empty channel.
                if (adv[g] && empty) begin
                    uf <= 1'b1;
                end
                if (push[g] && !pop) begin
                    cnt <= cnt + (AW+1)'(1);
                end else if (pop && !push[g]) begin
                    cnt <= cnt - (AW+1)'(1);
                end
            end
        end
    end

    assign IN1        = head[0];
    assign IN2        = head[1];
    assign count1     = count[0];
    assign count2     = count[1];
    assign underflow1 = underflow[0];
    assign underflow2 = underflow[1];

endmodule

// File: tb/tb_hovalaag_input_fifo.sv
// Bench for hovalaag_input_fifo: queue-based channel model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hovalaag_input_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_sel;
    logic [11:0]   wr_data;
    logic          wr_ready;
    logic [11:0]   IN1;
    logic          IN1_adv;
    logic [11:0]   IN2;
    logic          IN2_adv;
    logic [AW:0]   count1;
    logic [AW:0]   count2;
    logic          underflow1;
    logic          underflow2;

    int errors = 0;
    int checks = 0;

    hovalaag_input_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .IN1        (IN1),
        .IN1_adv    (IN1_adv),
        .IN2        (IN2),
        .IN2_adv    (IN2_adv),
        .count1     (count1),
        .count2     (count2),
        .underflow1 (underflow1),
        .underflow2 (underflow2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel model: plain queues, sizes sampled before the edge decide push/pop legality.
    logic [11:0] q1[$];
    logic [11:0] q2[$];
    logic        uf1 = 1'b0;
    logic        uf2 = 1'b0;
    logic        started = 1'b0;
    int          s1;
    int          s2;

    always @(posedge clk) begin
        if (rst) begin
            q1.delete();
            q2.delete();
            uf1 = 1'b0;
            uf2 = 1'b0;
            started = 1'b1;
        end else begin
            s1 = q1.size();
            s2 = q2.size();
            if (IN1_adv) begin
                if (s1 > 0) void'(q1.pop_front());
                else uf1 = 1'b1;
            end
            if (IN2_adv) begin
                if (s2 > 0) void'(q2.pop_front());
                else uf2 = 1'b1;
            end
            if (wr_valid && !wr_sel && s1 < DEPTH) q1.push_back(wr_data);
            if (wr_valid &&  wr_sel && s2 < DEPTH) q2.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in1",   32'(IN1),   (q1.size() > 0) ? 32'(q1[0]) : 32'h0);
            chk("m_in2",   32'(IN2),   (q2.size() > 0) ? 32'(q2[0]) : 32'h0);
            chk("m_count1", 32'(count1), 32'(q1.size()));
            chk("m_count2", 32'(count2), 32'(q2.size()));
            chk("m_uf1",   32'(underflow1), 32'(uf1));
            chk("m_uf2",   32'(underflow2), 32'(uf2));
            chk("m_wr_ready", 32'(wr_ready),
                32'(((wr_sel ? q2.size() : q1.size()) < DEPTH) ? 1 : 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        IN1_adv  = 1'b0;
        IN2_adv  = 1'b0;
    endtask

    task automatic push(input logic sel, input logic [11:0] d);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_sel = 1'b0; wr_data = '0;
        idle();
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_count1", 32'(count1), 32'd0);
        chk("rst_in1",    32'(IN1),    32'h0);
        chk("rst_ready",  32'(wr_ready), 32'd1);
        chk("rst_uf1",    32'(underflow1), 32'd0);

        // Single push latency
        push(1'b0, 12'h123);
        chk("p1_in1",    32'(IN1),    32'h123);
        chk("p1_count1", 32'(count1), 32'd1);
        chk("p1_in2",    32'(IN2),    32'h0);
        chk("p1_count2", 32'(count2), 32'd0);
        IN1_adv = 1'b1; cyc(); idle();
        chk("p1_drain",  32'(count1), 32'd0);

        // Fill ch2, overflow attempt, drain in order
        for (int i = 1; i <= 16; i++) push(1'b1, 12'(i));
        chk("full_count2", 32'(count2), 32'd16);
        wr_sel = 1'b1; #1;
        chk("full_ready_sel1", 32'(wr_ready), 32'd0);
        wr_sel = 1'b0; #1;
        chk("full_ready_sel0", 32'(wr_ready), 32'd1);
        push(1'b1, 12'h099);
        chk("ovf_count2", 32'(count2), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_in2", 32'(IN2), 32'(i));
            IN2_adv = 1'b1; cyc();
        end
        idle();
        chk("drain_empty_in2", 32'(IN2), 32'h0);
        chk("drain_empty_cnt", 32'(count2), 32'd0);

        // Push+pop on full ch2: only the pop happens
        for (int i = 1; i <= 16; i++) push(1'b1, 12'(12'h100 + 12'(i)));
        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 12'hFFF; IN2_adv = 1'b1;
        cyc(); idle();
        chk("fullpp_count2", 32'(count2), 32'd15);
        chk("fullpp_in2",    32'(IN2),    32'h102);
        for (int i = 0; i < 15; i++) begin
            chk("fullpp_seq", 32'(IN2), 32'(12'h102 + 12'(i)));
            IN2_adv = 1'b1; cyc();
        end
        idle();
        chk("fullpp_empty", 32'(count2), 32'd0);

        // Steady push+pop through pointer wrap
        push(1'b0, 12'd10); push(1'b0, 12'd11); push(1'b0, 12'd12);
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 12'(13 + i); IN1_adv = 1'b1;
            cyc();
            chk("wrap_count1", 32'(count1), 32'd3);
            chk("wrap_in1",    32'(IN1),    32'(11 + i));
        end
        idle();
        IN1_adv = 1'b1; cyc(); cyc(); cyc(); idle();
        chk("wrap_drained", 32'(count1), 32'd0);
        chk("wrap_no_uf",   32'(underflow1), 32'd0);

        // Push+pop on empty ch1: push only, underflow set and sticky
        wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 12'hABC; IN1_adv = 1'b1;
        cyc(); idle();
        chk("epp_uf1",    32'(underflow1), 32'd1);
        chk("epp_count1", 32'(count1), 32'd1);
        chk("epp_in1",    32'(IN1),    32'hABC);
        IN1_adv = 1'b1; cyc(); idle();
        push(1'b0, 12'h001); cyc();
        chk("epp_uf1_sticky", 32'(underflow1), 32'd1);
        chk("epp_uf2_clear",  32'(underflow2), 32'd0);
        IN1_adv = 1'b1; cyc(); idle();

        // Both channels popped together
        push(1'b0, 12'h011); push(1'b0, 12'h012);
        push(1'b1, 12'h021); push(1'b1, 12'h022);
        IN1_adv = 1'b1; IN2_adv = 1'b1; cyc(); idle();
        chk("dual_count1", 32'(count1), 32'd1);
        chk("dual_count2", 32'(count2), 32'd1);
        chk("dual_in1",    32'(IN1),    32'h012);
        chk("dual_in2",    32'(IN2),    32'h022);

        // Reset mid-stream overrides push and pops
        for (int i = 0; i < 7; i++) begin
            push(1'b0, 12'(12'h200 + 12'(i)));
            push(1'b1, 12'(12'h300 + 12'(i)));
        end
        rst = 1'b1; wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 12'h777;
        IN1_adv = 1'b1; IN2_adv = 1'b1;
        cyc();
        rst = 1'b0; idle();
        chk("mrst_count1", 32'(count1), 32'd0);
        chk("mrst_count2", 32'(count2), 32'd0);
        chk("mrst_in1",    32'(IN1),    32'h0);
        chk("mrst_in2",    32'(IN2),    32'h0);
        chk("mrst_uf1",    32'(underflow1), 32'd0);
        chk("mrst_ready",  32'(wr_ready), 32'd1);
        push(1'b1, 12'h5A5);
        chk("post_rst_in2",    32'(IN2),    32'h5A5);
        chk("post_rst_count2", 32'(count2), 32'd1);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
